// File: rtl/cond_unit_pkg.sv
// Shared ARM definitions: condition-code encodings and NZCV flag bit positions.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational condition-field evaluator: Cond x {N,Z,C,V} -> CondEx.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            // Unconditional space is unsupported: never execute.
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register plus condition gating of the decoder's PC/register/memory write requests.
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       nReset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       flag_upd;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    // Condition is evaluated on pre-update flags; the write lands at the edge.
    assign flag_upd = CondEx & ~Stall;

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            flags_q <= 4'b0000;
        end else if (flag_upd) begin
            if (FlagW[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagW[0]) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expectations queued at drive time, popped when outputs settle.
module tb_cond_unit;

    logic       CLK = 1'b0;
    logic       nReset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, Stall;
    logic       CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0] Flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       condex;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mflags;

    cond_unit dut (
        .CLK      (CLK),
        .nReset   (nReset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .Stall    (Stall),
        .CondEx   (CondEx),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Called shortly after a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                        input logic pcs, input logic regw, input logic memw,
                        input logic nowr, input logic stall);
        exp_t e, got;
        logic ce;
        Cond = c; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr; Stall = stall;
        if (!nReset) mflags = 4'b0000;
        ce = cond_model(c, mflags);
        e.condex   = ce;
        e.pcsrc    = pcs & ce;
        e.regwrite = regw & ce & ~nowr;
        e.memwrite = memw & ce;
        e.flags    = mflags;
        sb.push_back(e);
        #1;
        got = {CondEx, PCSrc, RegWrite, MemWrite, Flags};
        e = sb.pop_front();
        chk("condex",   got.condex,   e.condex);
        chk("pcsrc",    got.pcsrc,    e.pcsrc);
        chk("regwrite", got.regwrite, e.regwrite);
        chk("memwrite", got.memwrite, e.memwrite);
        chk("flags",    got.flags,    e.flags);
        @(posedge CLK);
        if (nReset && ce && !stall) begin
            if (fw[1]) mflags[3:2] = af[3:2];
            if (fw[0]) mflags[1:0] = af[1:0];
        end
        @(negedge CLK);
    endtask

    initial begin
        nReset = 1'b0; mflags = 4'b0000;
        Cond = 4'h0; ALUFlags = 4'hF; FlagW = 2'b11;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Stall = 0;

        // Reset holds flags at zero despite a pending full update.
        step(4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0);
        chk("rst_flags", Flags, 4'h0);
        chk("rst_eq_fails", CondEx, 1'b0);
        step(4'h1, 4'hF, 2'b11, 1, 1, 1, 0, 0);
        chk("rst_ne_passes", CondEx, 1'b1);
        nReset = 1'b1;
        step(4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
        chk("rel_flags_1111", Flags, 4'hF);

        // Full condition sweep across every flag combination.
        for (int f = 0; f < 16; f++) begin
            step(4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                step(4'(c), 4'($urandom_range(0, 15)), 2'b00,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                if (f == 9 && c == 10) chk("ge_1001", CondEx, 1'b1);
                if (f == 9 && c == 12) chk("gt_1001", CondEx, 1'b1);
                if (c == 15) chk("nv_never", CondEx, 1'b0);
            end
        end

        // Partial per-group updates.
        step(4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0);
        step(4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 0);
        chk("partial_nz", Flags, 4'hC);
        step(4'hE, 4'h2, 2'b01, 0, 0, 0, 0, 0);
        chk("partial_cv", Flags, 4'hE);

        // Failed condition blocks writes and flag updates.
        step(4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0);
        step(4'h0, 4'h4, 2'b11, 1, 1, 1, 0, 0);
        chk("failcond_flags", Flags, 4'h0);

        // Compare op and stall.
        step(4'hE, 4'h6, 2'b11, 0, 1, 0, 1, 0);
        chk("cmp_flags", Flags, 4'h6);
        step(4'hE, 4'h9, 2'b11, 0, 1, 0, 0, 1);
        chk("stall_hold", Flags, 4'h6);
        step(4'hD, 4'h3, 2'b11, 1, 1, 1, 0, 1);

        // Async reset pulse between edges.
        step(4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
        chk("pre_async", Flags, 4'hF);
        #1 nReset = 1'b0;
        #1 chk("async_rst", Flags, 4'h0);
        mflags = 4'b0000;
        nReset = 1'b1;
        step(4'h1, 4'h5, 2'b11, 1, 1, 1, 0, 0);
        step(4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 0);

        if (sb.size() != 0) chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation and status-flag block for the single-cycle ARMv7 datapath; it is the consumer of the ALU's NZCV outputs. It holds the architectural N, Z, C, V flags in a register and evaluates each instruction's 4-bit condition field against the current flags. It gates the decoder's write requests (PC, register file, memory) so that failed-condition instructions have no architectural effect. It sits between the main decoder/ALU and the register file, PC mux and data-memory write enables.

## Interface
Parameters:
- none (flag width fixed at 4, condition field fixed at 4)

Ports:
- CLK  in  1  system clock, rising-edge
- nReset  in  1  asynchronous, active-low reset
- Cond  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU for the current instruction
- FlagW  in  2  bit1: update N,Z; bit0: update C,V (from decoder, S-bit qualified)
- PCS  in  1  decoder requests PC write (branch or Rd==PC)
- RegW  in  1  decoder requests register-file write
- MemW  in  1  decoder requests data-memory write
- NoWrite  in  1  compare/test op (TST/TEQ/CMP/CMN); suppresses RegWrite
- Stall  in  1  hold: no flag update this cycle
- CondEx  out  1  condition passed for current instruction
- PCSrc  out  1  PCS & CondEx
- RegWrite  out  1  RegW & CondEx & ~NoWrite
- MemWrite  out  1  MemW & CondEx
- Flags  out  4  registered {N,Z,C,V}

## Operation
- Flags register resets to 4'b0000 asynchronously whenever nReset=0. The reset takes effect mid-cycle and the new value is visible on Flags immediately.
- CondEx is combinational from Cond and registered Flags:
  - EQ 0000: Z; NE 0001: ~Z; CS 0010: C; CC 0011: ~C
  - MI 0100: N; PL 0101: ~N; VS 0110: V; VC 0111: ~V
  - HI 1000: C&~Z; LS 1001: ~C|Z; GE 1010: N==V; LT 1011: N!=V
  - GT 1100: ~Z&(N==V); LE 1101: Z|(N!=V); AL 1110: 1
  - 1111: 0. The unconditional space is not supported and is treated as never-execute.
- Flag update at rising CLK, per group, only when CondEx=1 and Stall=0:
  - FlagW[1]=1: N,Z <= ALUFlags[3:2]
  - FlagW[0]=1: C,V <= ALUFlags[1:0]
  - Groups not enabled hold their value.
- A failed-condition instruction never updates flags, even with FlagW set.
- Stall=1 freezes all four flags but does not mask the combinational outputs.
- Outputs PCSrc, RegWrite, MemWrite and CondEx are purely combinational, so there is no reset state beyond the one implied by Flags=0000. After reset, EQ fails, NE passes, and AL passes.

## Timing
- Condition evaluation has zero-cycle latency from Cond and Flags.
- Flag writes become visible the cycle after the writing instruction.
- An instruction that both tests and sets flags (e.g. ADDEQS) evaluates its condition against the pre-update flags. The update lands at the end of that cycle.
- Back-to-back flag setters: the second sees the first's result. There is no forwarding path and none is needed.
- ALUFlags is sampled only at the CLK edge. Glitches within the cycle are irrelevant.
- If nReset is asserted in the same cycle as an update, reset wins. Release is synchronised externally; no reset-release handling is needed here.

## Structure
- Shared package (common ARM definitions): condition-code constants COND_EQ..COND_AL, COND_NV. It also holds the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module, `cond_check`: purely combinational Cond×Flags → CondEx. It can be reused by a future pipelined version. The flag register and gating stay in `cond_unit`.

## Test plan
- Reset: drive nReset=0 with ALUFlags=4'b1111, FlagW=2'b11. Required: Flags=0000, and Cond=0000 gives CondEx=0 while Cond=0001 gives CondEx=1. Deassert nReset with Cond=1110 and check Flags=1111 after the next edge.
- Condition sweep: for each of the 16 Flags values (loaded via FlagW=11, Cond=1110), step Cond through 0..15. Compare CondEx to the table. Flags=1001 with Cond=1010 (GE) gives 1; Cond=1100 (GT) gives 1; Cond=1111 always gives 0.
- Partial update: Flags=0000, FlagW=2'b10, ALUFlags=4'b1111. Required: Flags=1100 next cycle. Then FlagW=2'b01, ALUFlags=4'b0010 gives Flags=1110.
- Failed condition: Flags=0000, Cond=0000, FlagW=11, ALUFlags=0100, PCS=RegW=MemW=1. Required: CondEx=0, PCSrc=RegWrite=MemWrite=0, and Flags stays 0000.
- Compare and stall: Cond=1110, NoWrite=1, RegW=1, FlagW=11, ALUFlags=0110. Required: RegWrite=0 and Flags=0110 next cycle. Repeat with Stall=1 and ALUFlags=1001: Flags holds 0110.
- Async reset mid-run: Flags=1111, pulse nReset low between clock edges. Required: Flags=0000 before the next edge.
